// File: rtl/ttc_seq_pkg5.sv
// Shared command codes, FSM states and select-vector layout for the
// triple-timer-counter configuration sequencer.
package ttc_seq_pkg5;

  localparam logic [2:0] CMD_CLK_CTRL  = 3'd0;
  localparam logic [2:0] CMD_CNTR_CTRL = 3'd1;
  localparam logic [2:0] CMD_INTERVAL  = 3'd2;
  localparam logic [2:0] CMD_MATCH_1   = 3'd3;
  localparam logic [2:0] CMD_MATCH_2   = 3'd4;
  localparam logic [2:0] CMD_MATCH_3   = 3'd5;
  localparam logic [2:0] CMD_INTR_EN   = 3'd6;
  localparam logic [2:0] CMD_RESTART   = 3'd7;

  localparam int RESTART_BIT5 = 4;

  localparam int SEL_CLK_CTRL  = 0;
  localparam int SEL_CNTR_CTRL = 1;
  localparam int SEL_INTERVAL  = 2;
  localparam int SEL_MATCH_1   = 3;
  localparam int SEL_MATCH_2   = 4;
  localparam int SEL_MATCH_3   = 5;
  localparam int SEL_INTR_EN   = 6;
  localparam int NUM_SEL       = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RS1,
    ST_RS2,
    ST_CLR
  } state_t;

  // One-hot register select for a plain write command; RESTART maps to nothing.
  function automatic logic [NUM_SEL-1:0] sel_decode(input logic [2:0] code);
    logic [NUM_SEL-1:0] sel;
    sel = '0;
    case (code)
      CMD_CLK_CTRL:  sel[SEL_CLK_CTRL]  = 1'b1;
      CMD_CNTR_CTRL: sel[SEL_CNTR_CTRL] = 1'b1;
      CMD_INTERVAL:  sel[SEL_INTERVAL]  = 1'b1;
      CMD_MATCH_1:   sel[SEL_MATCH_1]   = 1'b1;
      CMD_MATCH_2:   sel[SEL_MATCH_2]   = 1'b1;
      CMD_MATCH_3:   sel[SEL_MATCH_3]   = 1'b1;
      CMD_INTR_EN:   sel[SEL_INTR_EN]   = 1'b1;
      default:       sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ttc_cfg_sequencer_lite5_arb.sv
// Combinational round-robin picker: search starts at ptr, increases, wraps.
// The pointer register itself lives in the parent FSM.
module ttc_rr_arbiter5 #(
  parameter int NUM_REQ5 = 3,
  parameter int PTR_W    = 2
) (
  input  logic [NUM_REQ5-1:0] req,
  input  logic                en,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_REQ5-1:0] grant,
  output logic                grant_any,
  output logic [PTR_W-1:0]    grant_idx,
  output logic [PTR_W-1:0]    ptr_nxt
);

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ5; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ5) j = j - NUM_REQ5;
      if (en && !grant_any && req[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
    ptr_nxt = (grant_idx == PTR_W'(NUM_REQ5 - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/ttc_cfg_sequencer_lite5.sv
// Arbitrates register writes onto one timer instance, expands RESTART into a
// set/clear pair on the counter control register, and captures interrupts.
module ttc_cfg_sequencer_lite5
  import ttc_seq_pkg5::*;
#(
  parameter int NUM_REQ5 = 3,
  parameter int DATA_W5  = 16
) (
  input  logic                          pclk5,
  input  logic                          p_reset5,
  input  logic [NUM_REQ5-1:0]           req_valid5,
  input  logic [3*NUM_REQ5-1:0]         req_addr5,
  input  logic [DATA_W5*NUM_REQ5-1:0]   req_data5,
  output logic [NUM_REQ5-1:0]           req_ready5,
  output logic [DATA_W5-1:0]            pwdata5,
  output logic                          clk_ctrl_reg_sel5,
  output logic                          cntr_ctrl_reg_sel5,
  output logic                          interval_reg_sel5,
  output logic                          match_1_reg_sel5,
  output logic                          match_2_reg_sel5,
  output logic                          match_3_reg_sel5,
  output logic                          intr_en_reg_sel5,
  output logic                          clear_interrupt5,
  input  logic                          interrupt5,
  input  logic [5:0]                    interrupt_reg5,
  output logic                          irq_pending5,
  output logic [5:0]                    irq_status5,
  input  logic                          irq_ack5
);

  localparam int PTR_W = (NUM_REQ5 > 1) ? $clog2(NUM_REQ5) : 1;
  localparam logic [DATA_W5-1:0] RESTART_MASK = DATA_W5'(1) << RESTART_BIT5;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 arb_en;
  logic                 irq_take;
  logic [NUM_SEL-1:0]   sel;
  logic [DATA_W5-1:0]   lat_data;
  logic [DATA_W5-1:0]   win_data;
  logic [2:0]           win_addr;

  // A fresh interrupt pre-empts any grant in the same IDLE cycle.
  assign irq_take = interrupt5 && !irq_pending5;
  assign arb_en   = (state == ST_IDLE) && !irq_take && !p_reset5;

  ttc_rr_arbiter5 #(
    .NUM_REQ5 (NUM_REQ5),
    .PTR_W    (PTR_W)
  ) u_arb (
    .req       (req_valid5),
    .en        (arb_en),
    .ptr       (ptr),
    .grant     (req_ready5),
    .grant_any (grant_any),
    .grant_idx (grant_idx),
    .ptr_nxt   (ptr_nxt)
  );

  assign win_data = req_data5[int'(grant_idx)*DATA_W5 +: DATA_W5];
  assign win_addr = req_addr5[int'(grant_idx)*3 +: 3];

  always_ff @(posedge pclk5) begin
    if (p_reset5) begin
      state            <= ST_IDLE;
      ptr              <= '0;
      sel              <= '0;
      pwdata5          <= '0;
      lat_data         <= '0;
      clear_interrupt5 <= 1'b0;
      irq_pending5     <= 1'b0;
      irq_status5      <= '0;
    end else begin
      if (irq_ack5) irq_pending5 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (irq_take) begin
            state            <= ST_CLR;
            irq_status5      <= interrupt_reg5;
            clear_interrupt5 <= 1'b1;
          end else if (grant_any) begin
            ptr      <= ptr_nxt;
            lat_data <= win_data;
            if (win_addr == CMD_RESTART) begin
              state   <= ST_RS1;
              sel     <= sel_decode(CMD_CNTR_CTRL);
              pwdata5 <= win_data | RESTART_MASK;
            end else begin
              state   <= ST_WR;
              sel     <= sel_decode(win_addr);
              pwdata5 <= win_data;
            end
          end
        end
        ST_RS1: begin
          state   <= ST_RS2;
          sel     <= sel_decode(CMD_CNTR_CTRL);
          pwdata5 <= lat_data & ~RESTART_MASK;
        end
        ST_CLR: begin
          state            <= ST_IDLE;
          clear_interrupt5 <= 1'b0;
          irq_pending5     <= 1'b1;
        end
        default: begin
          state            <= ST_IDLE;
          sel              <= '0;
          pwdata5          <= '0;
          clear_interrupt5 <= 1'b0;
        end
      endcase
    end
  end

  assign clk_ctrl_reg_sel5  = sel[SEL_CLK_CTRL];
  assign cntr_ctrl_reg_sel5 = sel[SEL_CNTR_CTRL];
  assign interval_reg_sel5  = sel[SEL_INTERVAL];
  assign match_1_reg_sel5   = sel[SEL_MATCH_1];
  assign match_2_reg_sel5   = sel[SEL_MATCH_2];
  assign match_3_reg_sel5   = sel[SEL_MATCH_3];
  assign intr_en_reg_sel5   = sel[SEL_INTR_EN];

endmodule

// File: tb/tb_ttc_cfg_sequencer_lite5.sv
// Directed bench for ttc_cfg_sequencer_lite5: writes, round-robin order,
// RESTART expansion, interrupt capture/ack, and reset mid-sequence.
module tb_ttc_cfg_sequencer_lite5;

  localparam int N = 3;
  localparam int W = 16;

  logic          pclk5;
  logic          p_reset5;
  logic [N-1:0]  req_valid5;
  logic [3*N-1:0] req_addr5;
  logic [W*N-1:0] req_data5;
  logic [N-1:0]  req_ready5;
  logic [W-1:0]  pwdata5;
  logic          clk_ctrl_reg_sel5, cntr_ctrl_reg_sel5, interval_reg_sel5;
  logic          match_1_reg_sel5, match_2_reg_sel5, match_3_reg_sel5;
  logic          intr_en_reg_sel5;
  logic          clear_interrupt5;
  logic          interrupt5;
  logic [5:0]    interrupt_reg5;
  logic          irq_pending5;
  logic [5:0]    irq_status5;
  logic          irq_ack5;
  logic [6:0]    sel;

  int n_checks = 0;
  int n_errors = 0;

  ttc_cfg_sequencer_lite5 #(.NUM_REQ5(N), .DATA_W5(W)) dut (
    .pclk5              (pclk5),
    .p_reset5           (p_reset5),
    .req_valid5         (req_valid5),
    .req_addr5          (req_addr5),
    .req_data5          (req_data5),
    .req_ready5         (req_ready5),
    .pwdata5            (pwdata5),
    .clk_ctrl_reg_sel5  (clk_ctrl_reg_sel5),
    .cntr_ctrl_reg_sel5 (cntr_ctrl_reg_sel5),
    .interval_reg_sel5  (interval_reg_sel5),
    .match_1_reg_sel5   (match_1_reg_sel5),
    .match_2_reg_sel5   (match_2_reg_sel5),
    .match_3_reg_sel5   (match_3_reg_sel5),
    .intr_en_reg_sel5   (intr_en_reg_sel5),
    .clear_interrupt5   (clear_interrupt5),
    .interrupt5         (interrupt5),
    .interrupt_reg5     (interrupt_reg5),
    .irq_pending5       (irq_pending5),
    .irq_status5        (irq_status5),
    .irq_ack5           (irq_ack5)
  );

  // Select bits ordered by command code: bit k = select for code k.
  assign sel = {intr_en_reg_sel5, match_3_reg_sel5, match_2_reg_sel5, match_1_reg_sel5,
                interval_reg_sel5, cntr_ctrl_reg_sel5, clk_ctrl_reg_sel5};

  initial pclk5 = 1'b0;
  always #5 pclk5 = ~pclk5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk5);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] code, input logic [W-1:0] data);
    req_addr5[3*i +: 3] = code;
    req_data5[W*i +: W] = data;
  endtask

  task automatic do_reset();
    p_reset5 = 1'b1;
    req_valid5 = '0;
    tick();
    tick();
    p_reset5 = 1'b0;
  endtask

  initial begin
    req_valid5 = '0;
    req_addr5 = '0;
    req_data5 = '0;
    interrupt5 = 1'b0;
    interrupt_reg5 = '0;
    irq_ack5 = 1'b0;
    do_reset();

    // Reset state
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_pwdata", 32'(pwdata5), 32'h0);
    check("rst_clear", 32'(clear_interrupt5), 32'h0);
    check("rst_pending", 32'(irq_pending5), 32'h0);
    check("rst_status", 32'(irq_status5), 32'h0);
    check("rst_ready", 32'(req_ready5), 32'h0);

    // Single interval write
    set_req(0, 3'd2, 16'h1234);
    req_valid5 = 3'b001;
    #1;
    check("wr_ready", 32'(req_ready5), 32'h1);
    tick();
    req_valid5 = '0;
    check("wr_sel", 32'(sel), 32'h04);
    check("wr_pwdata", 32'(pwdata5), 32'h1234);
    check("wr_ready_busy", 32'(req_ready5), 32'h0);
    tick();
    check("wr_sel_off", 32'(sel), 32'h0);
    check("wr_pwdata_off", 32'(pwdata5), 32'h0);

    // Round-robin with all three requesters holding match_1 writes
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'd3, 16'hA000 + 16'(i));
    req_valid5 = 3'b111;
    for (int g = 0; g < 4; g++) begin
      int e;
      e = g % N;
      #1;
      check("rr_ready", 32'(req_ready5), 32'(1 << e));
      tick();
      check("rr_sel", 32'(sel), 32'h08);
      check("rr_pwdata", 32'(pwdata5), 32'(16'hA000 + 16'(e)));
      check("rr_ready_wr", 32'(req_ready5), 32'h0);
      tick();
    end
    req_valid5 = '0;

    // RESTART from req1, with req0 waiting behind it
    do_reset();
    set_req(1, 3'd7, 16'h0003);
    req_valid5 = 3'b010;
    #1;
    check("rs_ready", 32'(req_ready5), 32'h2);
    tick();
    set_req(0, 3'd0, 16'h0055);
    req_valid5 = 3'b001;
    #1;
    check("rs1_sel", 32'(sel), 32'h02);
    check("rs1_pwdata", 32'(pwdata5), 32'h0013);
    check("rs1_ready", 32'(req_ready5), 32'h0);
    tick();
    check("rs2_sel", 32'(sel), 32'h02);
    check("rs2_pwdata", 32'(pwdata5), 32'h0003);
    check("rs2_ready", 32'(req_ready5), 32'h0);
    tick();
    check("rs_idle_sel", 32'(sel), 32'h0);
    check("rs_next_ready", 32'(req_ready5), 32'h1);
    tick();
    req_valid5 = '0;
    check("rs_next_sel", 32'(sel), 32'h01);
    check("rs_next_pwdata", 32'(pwdata5), 32'h0055);
    tick();

    // Interrupt beats a same-cycle request
    do_reset();
    interrupt5 = 1'b1;
    interrupt_reg5 = 6'b000101;
    set_req(0, 3'd4, 16'h0777);
    req_valid5 = 3'b001;
    #1;
    check("irq_ready_blocked", 32'(req_ready5), 32'h0);
    tick();
    check("clr_pulse", 32'(clear_interrupt5), 32'h1);
    check("clr_status", 32'(irq_status5), 32'h05);
    check("clr_pending_early", 32'(irq_pending5), 32'h0);
    check("clr_sel", 32'(sel), 32'h0);
    check("clr_ready", 32'(req_ready5), 32'h0);
    tick();
    check("clr_pulse_end", 32'(clear_interrupt5), 32'h0);
    check("clr_pending", 32'(irq_pending5), 32'h1);
    check("post_clr_ready", 32'(req_ready5), 32'h1);
    tick();
    req_valid5 = '0;
    check("post_clr_sel", 32'(sel), 32'h10);
    check("post_clr_pwdata", 32'(pwdata5), 32'h0777);
    tick();
    interrupt_reg5 = 6'b100010;
    tick();
    check("held_no_clear", 32'(clear_interrupt5), 32'h0);
    check("held_status", 32'(irq_status5), 32'h05);
    // Ack in the same cycle as a still-high interrupt: no capture this cycle
    irq_ack5 = 1'b1;
    tick();
    irq_ack5 = 1'b0;
    check("ack_pending", 32'(irq_pending5), 32'h0);
    check("ack_no_clear", 32'(clear_interrupt5), 32'h0);
    check("ack_status_hold", 32'(irq_status5), 32'h05);
    tick();
    check("recap_clear", 32'(clear_interrupt5), 32'h1);
    check("recap_status", 32'(irq_status5), 32'h22);
    tick();
    check("recap_pending", 32'(irq_pending5), 32'h1);
    interrupt5 = 1'b0;
    irq_ack5 = 1'b1;
    tick();
    irq_ack5 = 1'b0;
    check("final_ack", 32'(irq_pending5), 32'h0);

    // Reset during RS1 aborts the sequence and rewinds the pointer
    set_req(1, 3'd7, 16'h0021);
    req_valid5 = 3'b010;
    #1;
    check("rsr_ready", 32'(req_ready5), 32'h2);
    tick();
    req_valid5 = '0;
    check("rsr_rs1_pwdata", 32'(pwdata5), 32'h0031);
    p_reset5 = 1'b1;
    tick();
    p_reset5 = 1'b0;
    check("rsr_sel", 32'(sel), 32'h0);
    check("rsr_pwdata", 32'(pwdata5), 32'h0);
    check("rsr_status", 32'(irq_status5), 32'h0);
    check("rsr_clear", 32'(clear_interrupt5), 32'h0);
    set_req(1, 3'd6, 16'h0B0B);
    set_req(2, 3'd6, 16'h0C0C);
    req_valid5 = 3'b110;
    #1;
    check("rsr_ptr_ready", 32'(req_ready5), 32'h2);
    tick();
    req_valid5 = '0;
    check("rsr_wr_sel", 32'(sel), 32'h40);
    check("rsr_wr_pwdata", 32'(pwdata5), 32'h0B0B);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
